aes_inv_cipher_iter: RTL

Iterative AES-128 inverse cipher: accepts one 128-bit ciphertext block over a valid/ready handshake and returns the 128-bit plaintext, one inverse round per clock. It is the decryption counterpart of the pipelined forward AES round datapath. Round keys come from the existing expanded-key store through an indexed read port. It sits beside the encryption path in the AES subsystem, for key-check and loopback test of the OFDM baseband crypto.

---
 rtl/aes_inv_cipher_iter_pkg.sv | 73 +++++++
 rtl/aes_inv_cipher_iter_inv_sub_bytes.sv | 14 +
 rtl/aes_inv_cipher_iter.sv | 115 +++++++++++
 3 files changed

// File: rtl/aes_inv_cipher_iter_pkg.sv
// Shared definitions for the iterative AES-128 inverse cipher: round count, FSM states,
// GF(2^8) helpers, byte indexing and the inverse S-box table.
package aes_inv_cipher_iter_pkg;

    localparam int unsigned NR = 10;

    typedef enum logic [1:0] {
        StIdle,
        StRound,
        StDone
    } fsm_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant (used with 09/0b/0d/0e) from chained xtime.
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (c[3] ? x8 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^
               (c[1] ? x2 : 8'h00) ^ (c[0] ? b : 8'h00);
    endfunction

    // Column-major byte index: byte 0 sits in bits [127:120].
    function automatic int unsigned bidx(input int unsigned row, input int unsigned col);
        return row + 4 * col;
    endfunction

    function automatic logic [7:0] get_byte(input logic [127:0] s, input int unsigned idx);
        return s[127 - 8 * idx -: 8];
    endfunction

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/aes_inv_cipher_iter_inv_sub_bytes.sv
// Sixteen parallel inverse S-box lookups; purely combinational so a whole inverse round
// fits in one clock.
module aes_inv_cipher_iter_inv_sub_bytes
    import aes_inv_cipher_iter_pkg::*;
(
    input  logic [127:0] data_in,
    output logic [127:0] data_out
);

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        assign data_out[127 - 8 * i -: 8] = INV_SBOX[data_in[127 - 8 * i -: 8]];
    end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one ciphertext block in over valid/ready, one inverse
// round per clock, plaintext out over valid/ready. Round keys are read by index.
module aes_inv_cipher_iter
    import aes_inv_cipher_iter_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data
);

    fsm_e         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;

    logic [127:0] shifted;
    logic [127:0] subbed;
    logic [127:0] added;
    logic [127:0] mixed;

    // Row r rotates right by r byte positions.
    always_comb begin
        shifted = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                shifted[127 - 8 * bidx(r, c) -: 8] =
                    get_byte(state_q, bidx(r, (c + 4 - r) % 4));
            end
        end
    end

    aes_inv_cipher_iter_inv_sub_bytes u_inv_sub_bytes (
        .data_in  (shifted),
        .data_out (subbed)
    );

    assign added = subbed ^ rk_data;

    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        mixed = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = get_byte(added, bidx(0, c));
            a1 = get_byte(added, bidx(1, c));
            a2 = get_byte(added, bidx(2, c));
            a3 = get_byte(added, bidx(3, c));
            mixed[127 - 8 * bidx(0, c) -: 8] =
                gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
            mixed[127 - 8 * bidx(1, c) -: 8] =
                gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
            mixed[127 - 8 * bidx(2, c) -: 8] =
                gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
            mixed[127 - 8 * bidx(3, c) -: 8] =
                gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
        end
    end

    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        rnd_d     = rnd_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        rk_idx    = 4'(NR);
        unique case (fsm_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = data_in ^ rk_data;
                    rnd_d   = 4'(NR - 1);
                    fsm_d   = StRound;
                end
            end
            StRound: begin
                rk_idx = rnd_q;
                if (rnd_q == 4'd0) begin
                    // Final round skips InvMixColumns.
                    state_d = added;
                    fsm_d   = StDone;
                end else begin
                    state_d = mixed;
                    rnd_d   = rnd_q - 4'd1;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    fsm_d = StIdle;
                end
            end
            default: fsm_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= StIdle;
            state_q <= '0;
            rnd_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rnd_q   <= rnd_d;
        end
    end

    assign data_out = state_q;

endmodule
